mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 13, memory address width.
REQ-002 The block SHALL have parameter DATA_W, default 32, data width.
REQ-003 The block SHALL have parameter MAX_STREAK, default 4, consecutive data grants allowed while fetch waits.
REQ-004 The block SHALL have these ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- if_req  in  1  fetch request, held until if_gnt.
- if_addr  in  ADDR_W  fetch address.
- if_flush  in  1  discard the in-flight fetch (taken branch/jump).
- if_gnt  out  1  fetch accepted, 1-cycle pulse.
- if_rvalid  out  1  instruction valid, 1-cycle pulse.
- if_rdata  out  DATA_W  instruction word.
- d_req  in  1  load/store request, held until d_gnt.
- d_we  in  1  1 = store.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  store data.
- d_funct3  in  3  access size/sign.
- d_gnt  out  1  data accepted, 1-cycle pulse.
- d_rvalid  out  1  load data valid or store done, 1-cycle pulse.
- d_rdata  out  DATA_W  load data.
- mem_req  out  1  memory access active.
- mem_we, mem_addr, mem_wdata, mem_funct3  out  1/ADDR_W/DATA_W/3  memory command.
- mem_ready  in  1  memory done this cycle.
- mem_rdata  in  DATA_W  memory read data, valid with mem_ready.

Function
REQ-005 FSM states SHALL be IDLE, BUSY, RESP; exactly one access is outstanding at any time.
REQ-006 In IDLE with any request, the block SHALL pulse the winner's gnt combinationally, register its command into mem_* and the owner, then go to BUSY.
REQ-007 Default priority SHALL be data over fetch.
REQ-008 In BUSY, mem_req SHALL be 1 and mem_* SHALL hold stable until mem_ready is sampled 1; mem_rdata SHALL then be registered and the FSM SHALL go to RESP.
REQ-009 In RESP, the owner's rvalid SHALL pulse for one cycle with the registered rdata; the FSM SHALL return to IDLE.
REQ-010 Minimum latency SHALL be gnt at cycle N, mem_req at N+1, and rvalid at N+2 when mem_ready=1 at N+1; peak throughput is one access per 3 cycles.
REQ-011 A store SHALL produce d_rvalid as its completion pulse; d_rdata is then don't-care.
REQ-012 if_flush in BUSY or RESP with a fetch owner SHALL mark that fetch killed: the memory access completes, but if_rvalid SHALL stay 0.
REQ-013 if_flush in IDLE SHALL block a fetch grant that cycle; d_req is unaffected.
REQ-014 if_rdata/d_rdata SHALL hold their last value outside rvalid; mem_req SHALL be 0 in IDLE and RESP.
REQ-015 Both requests together with no pending streak limit: data granted, fetch waits.

Reset
REQ-016 rst=0 SHALL asynchronously force IDLE, the streak counter to 0, the kill flag to 0, and all outputs to 0.
REQ-017 A reset mid-access SHALL drop the transaction with no rvalid; mem_req SHALL fall immediately.

Configuration
REQ-018 With MEM_ARB_FAIRNESS_EN defined, a counter SHALL count data grants given while if_req=1; at MAX_STREAK the next grant SHALL go to fetch, and a fetch grant SHALL clear the counter.
REQ-019 Without MEM_ARB_FAIRNESS_EN, the block SHALL use strict data priority with no counter logic.

Structure
REQ-020 A shared package mem_arb_pkg SHALL hold the state encoding, the owner encoding (OWN_IF, OWN_D), and the streak counter width.
REQ-021 The priority/fairness decision SHALL be one sub-module, mem_arb_pick (combinational, takes requests and the streak count).

Verification
REQ-022 Single fetch: if_req, if_addr=0x004, mem_ready=1 at first BUSY cycle, mem_rdata=0x00000033 -> if_gnt at N, mem_req at N+1, if_rvalid with 0x00000033 at N+2.
REQ-023 Simultaneous requests: if_req=d_req=1, d_we=1, d_addr=0x010, d_wdata=0xDEADBEEF -> d_gnt first, mem_we=1, d_rvalid; if_gnt in the next IDLE.
REQ-024 Flush: fetch in BUSY, if_flush=1, mem_ready after 3 cycles -> no if_rvalid; the next request is granted normally.
REQ-025 Fairness (macro on, MAX_STREAK=4): d_req held continuously with if_req=1 -> 4 d_gnt pulses, then if_gnt, then data again; with the macro off, no if_gnt while d_req=1.
REQ-026 Reset mid-BUSY: rst=0 while mem_req=1 -> mem_req=0 immediately, no rvalid; after release, IDLE and fresh arbitration.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared encodings for the instruction/data memory arbiter
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_t;

    localparam int STREAK_W = 8;

    // Fetches always read a full word
    localparam logic [2:0] FUNCT3_WORD = 3'b010;

endpackage

// File: rtl/mem_arb_pick.sv
// rtl/mem_arb_pick.sv - combinational winner select: data first unless fetch has waited MAX_STREAK grants
module mem_arb_pick
    import mem_arb_pkg::*;
#(
    parameter int MAX_STREAK = 4
) (
    input  logic                if_req,
    input  logic                d_req,
    input  logic [STREAK_W-1:0] streak,
    output logic                pick_if,
    output logic                pick_d
);

    logic fetch_due;

    always_comb begin
        fetch_due = if_req && (streak >= STREAK_W'(MAX_STREAK));
        pick_d    = d_req && !fetch_due;
        pick_if   = if_req && !pick_d;
    end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - single-outstanding fetch/data memory arbiter; MEM_ARB_FAIRNESS_EN enables the fetch streak limit
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = 13,
    parameter int DATA_W     = 32,
    parameter int MAX_STREAK = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_flush,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    input  logic [2:0]        d_funct3,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [2:0]        mem_funct3,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata
);

    arb_state_t          state_q, state_d;
    owner_t              owner_q;
    logic                kill_q;
    logic [DATA_W-1:0]   rdata_q, if_hold_q, d_hold_q;
    logic [STREAK_W-1:0] streak_q;
    logic                pick_if, pick_d;

    mem_arb_pick #(
        .MAX_STREAK(MAX_STREAK)
    ) u_pick (
        .if_req (if_req && !if_flush),
        .d_req  (d_req),
        .streak (streak_q),
        .pick_if(pick_if),
        .pick_d (pick_d)
    );

    always_comb begin
        state_d = state_q;
        if_gnt  = 1'b0;
        d_gnt   = 1'b0;
        case (state_q)
            IDLE: begin
                // Grants are combinational, so keep them quiet while reset is held
                if (rst) begin
                    if_gnt = pick_if;
                    d_gnt  = pick_d;
                    if (pick_if || pick_d) state_d = BUSY;
                end
            end
            BUSY:    if (mem_ready) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign mem_req   = (state_q == BUSY);
    // A flush landing in the response cycle still suppresses the pulse
    assign if_rvalid = (state_q == RESP) && (owner_q == OWN_IF) && !kill_q && !if_flush;
    assign d_rvalid  = (state_q == RESP) && (owner_q == OWN_D);
    assign if_rdata  = if_rvalid ? rdata_q : if_hold_q;
    assign d_rdata   = d_rvalid ? rdata_q : d_hold_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            owner_q    <= OWN_IF;
            kill_q     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_funct3 <= '0;
            rdata_q    <= '0;
            if_hold_q  <= '0;
            d_hold_q   <= '0;
        end else begin
            state_q <= state_d;
            if (d_gnt) begin
                owner_q    <= OWN_D;
                mem_we     <= d_we;
                mem_addr   <= d_addr;
                mem_wdata  <= d_wdata;
                mem_funct3 <= d_funct3;
            end else if (if_gnt) begin
                owner_q    <= OWN_IF;
                mem_we     <= 1'b0;
                mem_addr   <= if_addr;
                mem_wdata  <= '0;
                mem_funct3 <= FUNCT3_WORD;
            end
            if (state_q == BUSY && mem_ready) rdata_q <= mem_rdata;
            if (if_rvalid) if_hold_q <= rdata_q;
            if (d_rvalid) d_hold_q <= rdata_q;
            if (state_q == IDLE) kill_q <= 1'b0;
            else if (if_flush && owner_q == OWN_IF) kill_q <= 1'b1;
        end
    end

`ifdef MEM_ARB_FAIRNESS_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            streak_q <= '0;
        end else if (if_gnt) begin
            streak_q <= '0;
        end else if (d_gnt && if_req && streak_q < STREAK_W'(MAX_STREAK)) begin
            streak_q <= streak_q + STREAK_W'(1);
        end
    end
`else
    assign streak_q = '0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - randomized scoreboard bench for mem_arbiter (honours MEM_ARB_FAIRNESS_EN)
module tb_mem_arbiter;

    localparam int ADDR_W = 13;
    localparam int DATA_W = 32;
    localparam int MAX_STREAK = 4;
`ifdef MEM_ARB_FAIRNESS_EN
    localparam bit FAIR_ON = 1'b1;
`else
    localparam bit FAIR_ON = 1'b0;
`endif
    localparam int M_IDLE = 0;
    localparam int M_BUSY = 1;
    localparam int M_RESP = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              if_req, if_flush, if_gnt, if_rvalid;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              d_req, d_we, d_gnt, d_rvalid;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata, d_rdata;
    logic [2:0]        d_funct3;
    logic              mem_req, mem_we, mem_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata, mem_rdata;
    logic [2:0]        mem_funct3;

    mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_STREAK(MAX_STREAK)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_funct3(d_funct3),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_funct3(mem_funct3), .mem_ready(mem_ready), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_d;
        bit          is_store;
        logic [31:0] data;
    } exp_t;

    exp_t        exp_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    bit          mon_en = 1'b0;
    logic [31:0] last_if = '0;
    logic [31:0] last_d = '0;
    bit          d_known = 1'b1;
    logic [31:0] ref_mem[16];
    logic [31:0] mem_arr[16];

    // Bench model of the arbiter: phase, streak and the transaction in flight
    int          st = M_IDLE;
    int          streak_m = 0;
    bit          g_if = 0, g_d = 0, rdy = 0;
    bit          cur_d, cur_we, cur_killed;
    logic [12:0] cur_addr;
    logic [31:0] cur_wdata;
    logic [2:0]  cur_f3;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (if_rvalid || d_rvalid) begin
                    if (if_rvalid && d_rvalid) chk("both_rvalid", 1, 0);
                    if (exp_q.size() == 0) begin
                        chk("unexpected_rvalid", {if_rvalid, d_rvalid}, 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("rvalid_port", {if_rvalid, d_rvalid}, e.is_d ? 2'b01 : 2'b10);
                        if (!e.is_d) begin
                            chk("if_rdata", if_rdata, e.data);
                            last_if = e.data;
                        end else if (!e.is_store) begin
                            chk("d_rdata", d_rdata, e.data);
                            last_d  = e.data;
                            d_known = 1'b1;
                        end else begin
                            d_known = 1'b0;
                        end
                    end
                end else begin
                    chk("if_rdata_hold", if_rdata, last_if);
                    if (d_known) chk("d_rdata_hold", d_rdata, last_d);
                end
            end
        end
    end

    task automatic run_cycles(input int n, input bit new_ok, input bit drain, input int rst_at);
        bit   fetch_ok, exp_if, exp_d, rst_done;
        exp_t e;
        rst_done = 1'b0;
        for (int cyc = 0; cyc < n; cyc++) begin
            @(posedge clk);
            #1;
            case (st)
                M_IDLE:  if (g_if || g_d) st = M_BUSY;
                M_BUSY:  if (rdy) st = M_RESP;
                default: st = M_IDLE;
            endcase
            if (g_if) if_req = 1'b0;
            if (g_d) d_req = 1'b0;
            if (!if_req && new_ok && $urandom_range(0, 2) == 0) begin
                if_req  = 1'b1;
                if_addr = 13'($urandom_range(0, 15) * 4);
            end
            if (!d_req && new_ok && $urandom_range(0, 1) == 0) begin
                d_req    = 1'b1;
                d_we     = 1'($urandom_range(0, 1));
                d_addr   = 13'($urandom_range(0, 15) * 4);
                d_wdata  = $urandom;
                d_funct3 = 3'($urandom_range(0, 7));
            end
            if_flush = new_ok && ($urandom_range(0, 7) == 0);
            if (if_flush && st != M_IDLE && !cur_d && !cur_killed) begin
                cur_killed = 1'b1;
                if (exp_q.size() > 0) void'(exp_q.pop_back());
            end
            mem_ready = (st == M_BUSY) && (drain || $urandom_range(0, 1) == 1);
            mem_rdata = mem_ready ? mem_arr[mem_addr[5:2]] : $urandom;
            if (rst_at >= 0 && cyc >= rst_at && !rst_done && st == M_BUSY) begin
                mem_ready = 1'b0;
                #1 rst = 1'b0;
                #1;
                chk("rst_mem_req", mem_req, 0);
                chk("rst_mem_addr", mem_addr, 0);
                chk("rst_rvalid", {if_rvalid, d_rvalid}, 0);
                chk("rst_gnt", {if_gnt, d_gnt}, 0);
                exp_q.delete();
                st = M_IDLE;
                streak_m = 0;
                last_if = '0;
                last_d = '0;
                d_known = 1'b1;
                cur_killed = 1'b0;
                #1 rst = 1'b1;
                rst_done = 1'b1;
            end
            @(negedge clk);
            exp_if = 1'b0;
            exp_d  = 1'b0;
            if (st == M_IDLE) begin
                fetch_ok = if_req && !if_flush;
                if (d_req && !(FAIR_ON && fetch_ok && streak_m >= MAX_STREAK)) exp_d = 1'b1;
                else if (fetch_ok) exp_if = 1'b1;
            end
            chk("if_gnt", if_gnt, exp_if);
            chk("d_gnt", d_gnt, exp_d);
            if (st == M_BUSY) begin
                chk("mem_req_busy", mem_req, 1);
                chk("mem_addr", mem_addr, cur_addr);
                chk("mem_we", mem_we, cur_we);
                if (cur_d) chk("mem_funct3", mem_funct3, cur_f3);
                if (cur_d && cur_we) chk("mem_wdata", mem_wdata, cur_wdata);
                if (mem_ready && cur_d && cur_we) begin
                    ref_mem[cur_addr[5:2]] = cur_wdata;
                    mem_arr[mem_addr[5:2]] = mem_wdata;
                end
            end else begin
                chk("mem_req_idle", mem_req, 0);
            end
            if (exp_d) begin
                cur_d = 1'b1; cur_we = d_we; cur_addr = d_addr;
                cur_wdata = d_wdata; cur_f3 = d_funct3; cur_killed = 1'b0;
                e.is_d = 1'b1; e.is_store = d_we; e.data = ref_mem[d_addr[5:2]];
                exp_q.push_back(e);
                if (if_req && streak_m < MAX_STREAK) streak_m++;
            end else if (exp_if) begin
                cur_d = 1'b0; cur_we = 1'b0; cur_addr = if_addr; cur_killed = 1'b0;
                e.is_d = 1'b0; e.is_store = 1'b0; e.data = ref_mem[if_addr[5:2]];
                exp_q.push_back(e);
                streak_m = 0;
            end
            g_if = exp_if;
            g_d  = exp_d;
            rdy  = mem_ready;
        end
    endtask

    initial begin
        exp_t e;
        for (int i = 0; i < 16; i++) begin
            ref_mem[i] = $urandom;
            mem_arr[i] = ref_mem[i];
        end
        rst = 1'b0;
        if_req = 1'b1; if_addr = 13'h004; if_flush = 1'b0;
        d_req = 1'b1; d_we = 1'b1; d_addr = 13'h010; d_wdata = 32'hDEADBEEF; d_funct3 = 3'b010;
        mem_ready = 1'b0; mem_rdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_gnt", {if_gnt, d_gnt}, 0);
        chk("reset_mem_req", mem_req, 0);
        chk("reset_mem_cmd", {mem_we, mem_addr, mem_funct3}, 0);
        chk("reset_rvalid", {if_rvalid, d_rvalid}, 0);
        chk("reset_rdata", {if_rdata, d_rdata}, 0);
        if_req = 1'b0; d_req = 1'b0;
        #1 rst = 1'b1;
        mon_en = 1'b1;

        // Minimum-latency single fetch
        @(posedge clk); #1;
        if_req = 1'b1; if_addr = 13'h004;
        @(negedge clk);
        chk("lat_if_gnt_N", if_gnt, 1);
        chk("lat_d_gnt_N", d_gnt, 0);
        e.is_d = 1'b0; e.is_store = 1'b0; e.data = 32'h00000033;
        exp_q.push_back(e);
        @(posedge clk); #1;
        if_req = 1'b0; mem_ready = 1'b1; mem_rdata = 32'h00000033;
        @(negedge clk);
        chk("lat_mem_req_N1", mem_req, 1);
        chk("lat_mem_addr_N1", mem_addr, 13'h004);
        chk("lat_if_rvalid_N1", if_rvalid, 0);
        @(posedge clk); #1;
        mem_ready = 1'b0;
        @(negedge clk);
        chk("lat_if_rvalid_N2", if_rvalid, 1);
        chk("lat_if_rdata_N2", if_rdata, 32'h00000033);
        chk("lat_mem_req_N2", mem_req, 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("lat_if_rvalid_N3", if_rvalid, 0);

        run_cycles(600, 1'b1, 1'b0, 300);
        run_cycles(30, 1'b0, 1'b1, -1);
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
